// File: rtl/bsg_wormhole_packet_parser_multi_pkg.sv
// Shared helpers for the multi-flit wormhole packet parser.
package bsg_wormhole_packet_parser_multi_pkg;

  // Width of an index into n slots; never narrower than one bit.
  function automatic int safe_clog2(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bsg_wormhole_packet_parser_multi_hdr.sv
// Header capture array: one enabled register per header slot.

// Plain enabled register with synchronous active-high reset.
module bsg_dff_reset_en #(
  parameter int width_p = 1
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               en_i,
  input  logic [width_p-1:0] data_i,
  output logic [width_p-1:0] data_o
);

  // Load on enable, clear on reset.
  always_ff @(posedge clk_i) begin
    if (reset_i)   data_o <= '0;
    else if (en_i) data_o <= data_i;
  end

endmodule

// A first-flit deque loads slot 0 with the flit and clears every other slot,
// so slots a short packet never reaches read back as zero. A later header
// deque loads only the slot selected by idx_i.
module bsg_wormhole_packet_parser_multi_hdr
  import bsg_wormhole_packet_parser_multi_pkg::*;
#(
  parameter int flit_width_p    = 16,
  parameter int hdr_flits_p     = 1,
  parameter int hdr_idx_width_p = safe_clog2(hdr_flits_p)
) (
  input  logic                              clk_i,
  input  logic                              reset_i,
  input  logic [flit_width_p-1:0]           data_i,
  input  logic                              first_deq_i,
  input  logic                              hdr_deq_i,
  input  logic [hdr_idx_width_p-1:0]        idx_i,
  output logic [hdr_flits_p*flit_width_p-1:0] hdr_r_o
);

  for (genvar i = 0; i < hdr_flits_p; i++) begin : g_slot
    logic                    en;
    logic [flit_width_p-1:0] d;

    assign en = first_deq_i | (hdr_deq_i & (idx_i == hdr_idx_width_p'(i)));
    assign d  = (first_deq_i && (i != 0)) ? '0 : data_i;

    bsg_dff_reset_en #(.width_p(flit_width_p)) slot (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .en_i    (en),
      .data_i  (d),
      .data_o  (hdr_r_o[i*flit_width_p +: flit_width_p])
    );
  end

endmodule

// File: rtl/bsg_wormhole_packet_parser_multi.sv
// Streaming parser for wormhole packets with a multi-flit header.
// Flags describe the current fifo head combinationally; state moves only on
// a dequeue (fifo_yumi_i). The length field L counts flits after the first.
//
// Handshake: the head flit is offered when fifo_v_i is high; it is consumed
// in a cycle where fifo_yumi_i is high, which is only legal with fifo_v_i high.
module bsg_wormhole_packet_parser_multi
  import bsg_wormhole_packet_parser_multi_pkg::*;
#(
  parameter int flit_width_p = 16,
  parameter int len_width_p  = 4,
  parameter int len_offset_p = 0,
  parameter int hdr_flits_p  = 1
) (
  input  logic                                 clk_i,
  input  logic                                 reset_i,
  input  logic                                 fifo_v_i,
  input  logic [flit_width_p-1:0]              fifo_data_i,
  input  logic                                 fifo_yumi_i,
  output logic                                 first_o,
  output logic                                 hdr_o,
  output logic                                 last_o,
  output logic [safe_clog2(hdr_flits_p)-1:0]   hdr_idx_o,
  output logic [len_width_p-1:0]               flits_left_r_o,
  output logic [hdr_flits_p*flit_width_p-1:0]  hdr_r_o,
  output logic                                 hdr_v_r_o,
  output logic                                 short_o
);

  localparam int hdr_idx_width_lp = safe_clog2(hdr_flits_p);
  localparam logic [hdr_idx_width_lp-1:0] hdr_idx_last_lp = hdr_idx_width_lp'(hdr_flits_p - 1);

  // e_expect_first: the next flit to arrive starts a new packet.
  typedef enum logic {
    e_in_packet    = 1'b0,
    e_expect_first = 1'b1
  } state_e;

  state_e                      state_r, state_n;
  logic [len_width_p-1:0]      flits_left_r, flits_left_n;
  logic [hdr_idx_width_lp-1:0] hdr_idx_r, hdr_idx_n;
  logic                        hdr_v_r, hdr_v_n;
  logic [len_width_p-1:0]      len;
  logic                        in_pkt_v;
  logic                        first_deq, hdr_deq;

  assign len      = fifo_data_i[len_offset_p +: len_width_p];
  assign first_o  = fifo_v_i & (state_r == e_expect_first);
  assign in_pkt_v = fifo_v_i & (state_r == e_in_packet);
  assign hdr_o    = first_o | (in_pkt_v & (hdr_idx_r != '0));
  assign last_o   = first_o ? (len == '0)
                            : (in_pkt_v & (flits_left_r == len_width_p'(1)));
  assign hdr_idx_o = first_o ? '0 : hdr_idx_r;
  assign short_o   = last_o & hdr_o & (hdr_idx_o != hdr_idx_last_lp);

  assign flits_left_r_o = flits_left_r;
  assign hdr_v_r_o      = hdr_v_r;

  assign first_deq = fifo_yumi_i & first_o;
  assign hdr_deq   = fifo_yumi_i & in_pkt_v & hdr_o;

  // Next-state: first-flit deque opens a packet, later deques count it down.
  always_comb begin
    state_n      = state_r;
    flits_left_n = flits_left_r;
    hdr_idx_n    = hdr_idx_r;
    hdr_v_n      = hdr_v_r;
    if (first_deq) begin
      hdr_v_n = (hdr_flits_p == 1) || (len == '0);
      if (len != '0) begin
        state_n      = e_in_packet;
        flits_left_n = len;
        hdr_idx_n    = (hdr_flits_p > 1) ? hdr_idx_width_lp'(1) : '0;
      end
    end else if (fifo_yumi_i && in_pkt_v) begin
      flits_left_n = flits_left_r - len_width_p'(1);
      if (hdr_o) begin
        if (hdr_idx_r == hdr_idx_last_lp) begin
          hdr_idx_n = '0;
          hdr_v_n   = 1'b1;
        end else begin
          hdr_idx_n = hdr_idx_r + hdr_idx_width_lp'(1);
        end
      end
      if (last_o) begin
        state_n   = e_expect_first;
        hdr_idx_n = '0;
        hdr_v_n   = 1'b1;
      end
    end
  end

  // State registers; reset discards any partial packet.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r      <= e_expect_first;
      flits_left_r <= '0;
      hdr_idx_r    <= '0;
      hdr_v_r      <= 1'b0;
    end else begin
      state_r      <= state_n;
      flits_left_r <= flits_left_n;
      hdr_idx_r    <= hdr_idx_n;
      hdr_v_r      <= hdr_v_n;
    end
  end

  // Dequeuing an absent flit is a protocol error upstream.
  always_ff @(posedge clk_i) begin
    if (!reset_i) assert (!(fifo_yumi_i && !fifo_v_i));
  end

  bsg_wormhole_packet_parser_multi_hdr #(
    .flit_width_p    (flit_width_p),
    .hdr_flits_p     (hdr_flits_p),
    .hdr_idx_width_p (hdr_idx_width_lp)
  ) hdr_capture (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .data_i      (fifo_data_i),
    .first_deq_i (first_deq),
    .hdr_deq_i   (hdr_deq),
    .idx_i       (hdr_idx_r),
    .hdr_r_o     (hdr_r_o)
  );

endmodule
